// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing: counters, line/frame strobes, freezable game tick, delay-aligned sync/DE/RGB.
// Sync, DE and RGB lag the counters by PIPE+1 cycles to absorb the caller's pixel path; free-running, no backpressure.
module vga_timing_gen #(
  parameter int H_ACTIVE    = 800,
  parameter int H_FP        = 56,
  parameter int H_SYNC      = 120,
  parameter int H_BP        = 64,
  parameter int V_ACTIVE    = 600,
  parameter int V_FP        = 37,
  parameter int V_SYNC      = 6,
  parameter int V_BP        = 23,
  parameter bit HS_POL      = 1'b1,
  parameter bit VS_POL      = 1'b1,
  parameter int PIPE        = 1,
  parameter int TICK_FRAMES = 36,
  parameter int HW          = 11,
  parameter int VW          = 10
) (
  input  logic          vclk,
  input  logic          rst,
  input  logic          frz,
  input  logic [7:0]    pixel_in,
  output logic [HW-1:0] hcount,
  output logic [VW-1:0] vcount,
  output logic          line_start,
  output logic          frame_start,
  output logic          tick,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [2:0]    VGA_R,
  output logic [2:0]    VGA_G,
  output logic [1:0]    VGA_B
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;
  localparam int DW       = (TICK_FRAMES > 1) ? $clog2(TICK_FRAMES) : 1;

  if (H_TOTAL > (1 << HW)) begin : g_bad_hw
    $error("vga_timing_gen: H_TOTAL does not fit in HW bits");
  end
  if (V_TOTAL > (1 << VW)) begin : g_bad_vw
    $error("vga_timing_gen: V_TOTAL does not fit in VW bits");
  end
  if (PIPE < 0 || PIPE > 7) begin : g_bad_pipe
    $error("vga_timing_gen: PIPE must be within 0..7");
  end
  if (TICK_FRAMES < 1) begin : g_bad_tick
    $error("vga_timing_gen: TICK_FRAMES must be at least 1");
  end

  logic [31:0]   h_ext;
  logic [31:0]   v_ext;
  logic          h_wrap;
  logic          v_wrap;
  logic          act;
  logic          hs_raw;
  logic          vs_raw;
  logic [PIPE:0] hs_pipe;
  logic [PIPE:0] vs_pipe;
  logic [PIPE:0] de_pipe;
  logic [7:0]    pix_q;
  logic [DW-1:0] div_q;
  logic          div_hit;

  assign h_ext  = 32'(hcount);
  assign v_ext  = 32'(vcount);
  assign h_wrap = (h_ext == H_TOTAL - 1);
  assign v_wrap = (v_ext == V_TOTAL - 1);

  always_ff @(posedge vclk) begin
    if (rst) begin
      hcount <= '0;
      vcount <= '0;
    end else begin
      hcount <= h_wrap ? '0 : hcount + HW'(1);
      if (h_wrap) begin
        vcount <= v_wrap ? '0 : vcount + VW'(1);
      end
    end
  end

  assign act    = (h_ext < H_ACTIVE) && (v_ext < V_ACTIVE);
  assign hs_raw = (h_ext >= HS_START) && (h_ext < HS_END);
  assign vs_raw = (v_ext >= VS_START) && (v_ext < VS_END);

  // Strobes are masked during reset so nothing downstream sees a phantom frame start.
  assign line_start  = !rst && (hcount == '0);
  assign frame_start = line_start && (vcount == '0);

  assign div_hit = (div_q == DW'(TICK_FRAMES - 1));
  assign tick    = frame_start && !frz && div_hit;

  always_ff @(posedge vclk) begin
    if (rst) begin
      div_q <= '0;
    end else if (frame_start && !frz) begin
      div_q <= div_hit ? '0 : div_q + DW'(1);
    end
  end

  // Pipeline stores "asserted" flags; polarity is applied only at the output.
  always_ff @(posedge vclk) begin
    if (rst) begin
      hs_pipe <= '0;
      vs_pipe <= '0;
      de_pipe <= '0;
      pix_q   <= '0;
    end else begin
      hs_pipe[0] <= hs_raw;
      vs_pipe[0] <= vs_raw;
      de_pipe[0] <= act;
      for (int i = 1; i <= PIPE; i++) begin
        hs_pipe[i] <= hs_pipe[i-1];
        vs_pipe[i] <= vs_pipe[i-1];
        de_pipe[i] <= de_pipe[i-1];
      end
      pix_q <= pixel_in;
    end
  end

  assign hsync = hs_pipe[PIPE] ? HS_POL : ~HS_POL;
  assign vsync = vs_pipe[PIPE] ? VS_POL : ~VS_POL;
  assign de    = de_pipe[PIPE];
  assign VGA_R = de ? pix_q[7:5] : 3'd0;
  assign VGA_G = de ? pix_q[4:2] : 3'd0;
  assign VGA_B = de ? pix_q[1:0] : 2'd0;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomized-pixel bench for vga_timing_gen: three instances (default timing with both sync polarities and a tiny raster)
// checked every cycle against an arithmetic raster model derived from elapsed cycles since reset.
module tb_vga_timing_gen;

  typedef struct packed {
    int ha, hfp, hsw, hbp, va, vfp, vsw, vbp, pipe, tf, hpol, vpol;
  } cfg_t;

  logic       vclk = 1'b0;
  logic       rst = 1'b1;
  logic       frz = 1'b0;
  logic [7:0] pixel_in = 8'd0;

  always #5 vclk = ~vclk;

  logic [10:0] b0_hc, b1_hc;
  logic [9:0]  b0_vc, b1_vc;
  logic [3:0]  s_hc;
  logic [2:0]  s_vc;
  logic        b0_ls, b0_fs, b0_tk, b0_hs, b0_vs, b0_de;
  logic        b1_ls, b1_fs, b1_tk, b1_hs, b1_vs, b1_de;
  logic        s_ls, s_fs, s_tk, s_hs, s_vs, s_de;
  logic [2:0]  b0_r, b0_g, b1_r, b1_g, s_r, s_g;
  logic [1:0]  b0_b, b1_b, s_b;

  vga_timing_gen #(.HS_POL(1'b0), .VS_POL(1'b0)) u_b0 (
    .vclk(vclk), .rst(rst), .frz(frz), .pixel_in(pixel_in),
    .hcount(b0_hc), .vcount(b0_vc), .line_start(b0_ls), .frame_start(b0_fs), .tick(b0_tk),
    .hsync(b0_hs), .vsync(b0_vs), .de(b0_de), .VGA_R(b0_r), .VGA_G(b0_g), .VGA_B(b0_b)
  );

  vga_timing_gen u_b1 (
    .vclk(vclk), .rst(rst), .frz(frz), .pixel_in(pixel_in),
    .hcount(b1_hc), .vcount(b1_vc), .line_start(b1_ls), .frame_start(b1_fs), .tick(b1_tk),
    .hsync(b1_hs), .vsync(b1_vs), .de(b1_de), .VGA_R(b1_r), .VGA_G(b1_g), .VGA_B(b1_b)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b0), .PIPE(2), .TICK_FRAMES(3), .HW(4), .VW(3)
  ) u_s (
    .vclk(vclk), .rst(rst), .frz(frz), .pixel_in(pixel_in),
    .hcount(s_hc), .vcount(s_vc), .line_start(s_ls), .frame_start(s_fs), .tick(s_tk),
    .hsync(s_hs), .vsync(s_vs), .de(s_de), .VGA_R(s_r), .VGA_G(s_g), .VGA_B(s_b)
  );

  int   checks = 0;
  int   failures = 0;
  int   t = 0;
  bit   valid = 1'b0;
  int   cnt[3];
  logic [7:0] prev_pix = 8'd0;
  int   hs_run = 0;
  int   de_run = 0;
  int   last_ls = -1;
  cfg_t cb0, cb1, cs;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Expected outputs come from elapsed cycles t: position = t mod totals; delayed
  // outputs look at position t-PIPE-1; tick fires on every TF-th unfrozen frame start.
  task automatic check_inst(input int id, input cfg_t k, input logic [10:0] hc, input logic [9:0] vc,
                            input logic ls, input logic fs, input logic tk, input logic hs,
                            input logic vs, input logic dv, input logic [7:0] rgb);
    int   ht, vt, td, hd, vd;
    logic ls_e, fs_e, tk_e, a, hsa, vsa;
    ht   = k.ha + k.hfp + k.hsw + k.hbp;
    vt   = k.va + k.vfp + k.vsw + k.vbp;
    ls_e = !rst && (t % ht == 0);
    fs_e = ls_e && ((t / ht) % vt == 0);
    tk_e = 1'b0;
    if (fs_e && !frz) begin
      cnt[id]++;
      tk_e = (cnt[id] % k.tf == 0);
    end
    td  = t - k.pipe - 1;
    a   = 1'b0;
    hsa = 1'b0;
    vsa = 1'b0;
    if (td >= 0) begin
      hd  = td % ht;
      vd  = (td / ht) % vt;
      a   = (hd < k.ha) && (vd < k.va);
      hsa = (hd >= k.ha + k.hfp) && (hd < k.ha + k.hfp + k.hsw);
      vsa = (vd >= k.va + k.vfp) && (vd < k.va + k.vfp + k.vsw);
    end
    chk($sformatf("i%0d_hcount t=%0d", id, t), 32'(hc), 32'(t % ht));
    chk($sformatf("i%0d_vcount t=%0d", id, t), 32'(vc), 32'((t / ht) % vt));
    chk($sformatf("i%0d_line_start t=%0d", id, t), 32'(ls), 32'(ls_e));
    chk($sformatf("i%0d_frame_start t=%0d", id, t), 32'(fs), 32'(fs_e));
    chk($sformatf("i%0d_tick t=%0d", id, t), 32'(tk), 32'(tk_e));
    chk($sformatf("i%0d_hsync t=%0d", id, t), 32'(hs), 32'(hsa ? k.hpol : 1 - k.hpol));
    chk($sformatf("i%0d_vsync t=%0d", id, t), 32'(vs), 32'(vsa ? k.vpol : 1 - k.vpol));
    chk($sformatf("i%0d_de t=%0d", id, t), 32'(dv), 32'(a));
    chk($sformatf("i%0d_rgb t=%0d", id, t), 32'(rgb), a ? 32'(prev_pix) : 32'd0);
  endtask

  // One cycle: drive inputs, check the current state, then advance past the next edge.
  task automatic cyc(input logic r, input logic f);
    logic [7:0] px;
    px       = 8'($urandom);
    rst      = r;
    frz      = f;
    pixel_in = px;
    #1;
    if (valid) begin
      check_inst(0, cb0, b0_hc, b0_vc, b0_ls, b0_fs, b0_tk, b0_hs, b0_vs, b0_de, {b0_r, b0_g, b0_b});
      check_inst(1, cb1, b1_hc, b1_vc, b1_ls, b1_fs, b1_tk, b1_hs, b1_vs, b1_de, {b1_r, b1_g, b1_b});
      check_inst(2, cs, 11'(s_hc), 10'(s_vc), s_ls, s_fs, s_tk, s_hs, s_vs, s_de, {s_r, s_g, s_b});
      if (!r) begin
        if (b1_hs) hs_run++;
        else if (hs_run > 0) begin
          chk("b1_hsync_width", hs_run, 120);
          hs_run = 0;
        end
        if (b1_de) de_run++;
        else if (de_run > 0) begin
          chk("b1_de_width", de_run, 800);
          de_run = 0;
        end
        if (b1_ls) begin
          if (last_ls >= 0) chk("b1_line_period", t - last_ls, 1040);
          last_ls = t;
        end
      end
    end
    @(posedge vclk);
    #1;
    if (r) begin
      t       = 0;
      cnt     = '{0, 0, 0};
      valid   = 1'b1;
      hs_run  = 0;
      de_run  = 0;
      last_ls = -1;
    end else begin
      t++;
    end
    prev_pix = px;
  endtask

  initial begin
    cb0 = '{800, 56, 120, 64, 600, 37, 6, 23, 1, 36, 0, 0};
    cb1 = '{800, 56, 120, 64, 600, 37, 6, 23, 1, 36, 1, 1};
    cs  = '{8, 2, 2, 2, 4, 1, 1, 1, 2, 3, 1, 0};
    cnt = '{0, 0, 0};

    // Reset held three cycles, then free run across two full default lines and many small frames.
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0);
    for (int i = 0; i < 2200; i++) cyc(1'b0, 1'b0);

    // Freeze after two counted frames, hold five frames, release mid-frame.
    cyc(1'b1, 1'b0);
    for (int i = 0; i < 186; i++) cyc(1'b0, 1'b0);
    for (int i = 0; i < 490; i++) cyc(1'b0, 1'b1);
    for (int i = 0; i < 300; i++) cyc(1'b0, 1'b0);

    // Random freeze pattern.
    for (int i = 0; i < 600; i++) cyc(1'b0, ($urandom_range(0, 2) == 0));

    // Mid-operation reset at small-raster position (5,3).
    for (int i = 0; i < 200 && (t % 98) != 47; i++) cyc(1'b0, 1'b0);
    chk("t6_pre_reset_h", 32'(s_hc), 32'd5);
    chk("t6_pre_reset_v", 32'(s_vc), 32'd3);
    cyc(1'b1, 1'b0);
    for (int i = 0; i < 320; i++) cyc(1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised successor to the fixed 800x600 VGA timing logic. It generates the horizontal and vertical counters, sync, data-enable and frame/line strobes, and a freezable game-tick strobe that fires after a programmable number of frames. A caller-side pixel pipeline of configurable depth is compensated internally, so the RGB 3:3:2 outputs stay aligned with sync and data-enable. It runs in the pixel clock domain, alongside the grid overlay and game logic.

Parameters:
H_ACTIVE, 800, visible pixels per line
H_FP, 56, horizontal front porch (pixels)
H_SYNC, 120, horizontal sync width (pixels)
H_BP, 64, horizontal back porch (pixels); H_TOTAL = sum of the four = 1040
V_ACTIVE, 600, visible lines
V_FP, 37, vertical front porch (lines)
V_SYNC, 6, vertical sync width (lines)
V_BP, 23, vertical back porch (lines); V_TOTAL = sum of the four = 666
HS_POL, 1, hsync asserted level (1 = active-high)
VS_POL, 1, vsync asserted level
PIPE, 1, caller pixel-path latency in cycles (0..7)
TICK_FRAMES, 36, frames per game tick (>=1)
HW, 11, width of hcount
VW, 10, width of vcount

Ports:
vclk  in  1  pixel clock
rst  in  1  reset; synchronous, active-high
frz  in  1  freeze; suppresses game tick and holds the frame divider
pixel_in  in  8  pixel {R[2:0],G[2:0],B[1:0]} for the coordinates presented PIPE cycles earlier
hcount  out  HW  current horizontal position, 0..H_TOTAL-1
vcount  out  VW  current vertical position, 0..V_TOTAL-1
line_start  out  1  high while hcount==0
frame_start  out  1  high while hcount==0 and vcount==0
tick  out  1  one-cycle game-tick strobe
hsync  out  1  horizontal sync, delay-aligned
vsync  out  1  vertical sync, delay-aligned
de  out  1  data enable, delay-aligned
VGA_R  out  3  red
VGA_G  out  3  green
VGA_B  out  2  blue

Behaviour:
- Reset (rst high at a vclk edge):
  - hcount=0, vcount=0, frame divider=0.
  - All delay-pipeline stages are cleared: hsync=~HS_POL, vsync=~VS_POL, de=0, RGB=0.
  - tick=0. line_start and frame_start are held low while rst is high.
- Counters:
  - hcount increments every cycle; at H_TOTAL-1 it wraps to 0.
  - vcount increments only on the hcount wrap; at V_TOTAL-1 with the hcount wrap it wraps to 0.
  - There is no other wrap path.
- Decode, from the current counters:
  - act = (hcount < H_ACTIVE) && (vcount < V_ACTIVE).
  - hs_raw is asserted for hcount in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
  - vs_raw is asserted for vcount in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), across whole lines.
- Alignment and latency:
  - hs_raw, vs_raw and act pass through a PIPE+1 stage register delay to give hsync, vsync and de.
  - pixel_in is registered once. The RGB outputs equal the registered pixel_in when the delayed de=1, else 0 (forced blanking).
  - Net result: the outputs for coordinate (h,v) appear PIPE+1 cycles after hcount/vcount show (h,v).
  - Sync outputs are driven at the HS_POL/VS_POL level when asserted and at the inverse level otherwise.
- Game tick:
  - On a frame_start cycle with frz=0: if divider==TICK_FRAMES-1, tick=1 for that cycle and divider=0; otherwise divider increments.
  - frz=1: divider holds and tick=0. Timing outputs are unaffected by frz.
  - frz deasserting mid-frame resumes counting at the next frame_start.
  - TICK_FRAMES=1: tick fires on every unfrozen frame_start.
- Mid-operation reset: takes effect at the next edge and restarts from (0,0) with a clean pipeline.
- Legality: parameters must satisfy H_TOTAL <= 2^HW and V_TOTAL <= 2^VW; a violation is an elaboration error via a generate-time check.

Test Plan:
1. rst held 3 cycles with default parameters, HS_POL=VS_POL=0 -> during and on the cycle after release: hcount=0, vcount=0, hsync=1, vsync=1, de=0, RGB=0, tick=0; frame_start=1 on the first cycle after release.
2. Default parameters, PIPE=1, HS_POL=1 -> line_start period is 1040 cycles; hsync high for exactly 120 cycles, rising 2 cycles after hcount==856; de high for 800 cycles per visible line.
3. Small timing: H 8/2/2/2, V 4/1/1/1, PIPE=2, pixel_in = hcount[7:0] -> frame_start period 14*7=98 cycles; VGA_R/G/B show {hcount} values 0..7 exactly 3 cycles late; RGB=0 in blanking even though pixel_in is nonzero.
4. Small timing with TICK_FRAMES=3, frz=0 -> tick pulses one cycle on every 3rd frame_start (frames 3, 6, 9); pulse width exactly 1 cycle.
5. TICK_FRAMES=3, frz raised after 2 frames and held for 5 frames, then dropped -> no tick while frozen; the first tick occurs on the 1st frame_start after release (divider preserved at 2).
6. rst pulsed for 1 cycle at hcount=5, vcount=3 -> the next cycle shows hcount=0, vcount=0; the pipeline outputs are at idle levels for PIPE+1 cycles; the tick divider is back at 0.
